// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the parametrised register file.
// Width helpers live here so the top and the scoreboard derive ADDR_W identically.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned ZERO_REG     = 0;

  // Address width for a register count; a single bit minimum keeps ports legal.
  function automatic int unsigned addr_w(input int unsigned num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by an issuing producer,
// cleared by the write-back, with two combinational lookup ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  output logic              pend_a_c,
  output logic              pend_b_c
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  // Clear first, then set, so a newly issued producer wins over a retiring one.
  always_comb begin
    pend_d = pend_q;
    if (clr_i && (clr_addr_i != ADDR_W'(ZERO_REG))) begin
      pend_d[clr_addr_i] = 1'b0;
    end
    if (set_i && (set_addr_i != ADDR_W'(ZERO_REG))) begin
      pend_d[set_addr_i] = 1'b1;
    end
    pend_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_a_c = pend_q[addr_a_i];
  assign pend_b_c = pend_q[addr_b_i];

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: r0 hardwired to zero, two strobed registered read
// ports, one write port and a pending-write scoreboard. REGFILE_BYPASS_EN enables
// same-edge write-to-read forwarding.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic              rd_en,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic [DATA_W-1:0] out_data_a,
  output logic [DATA_W-1:0] out_data_b,
  output logic              out_valid,
  output logic              busy_a,
  output logic              busy_b
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_hit_c;
  logic              pend_a_c;
  logic              pend_b_c;
  logic [DATA_W-1:0] data_a_d;
  logic [DATA_W-1:0] data_b_d;
  logic              busy_a_d;
  logic              busy_b_d;
  logic [DATA_W-1:0] data_a_q;
  logic [DATA_W-1:0] data_b_q;
  logic              busy_a_q;
  logic              busy_b_q;
  logic              valid_q;

  assign wr_hit_c = wr_en && (rd != ADDR_W'(ZERO_REG));

  // Storage array; r0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_hit_c) begin
      regs_q[rd] <= i_data;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_i      (sb_set),
    .set_addr_i (sb_addr),
    .clr_i      (wr_hit_c),
    .clr_addr_i (rd),
    .addr_a_i   (rs),
    .addr_b_i   (rt),
    .pend_a_c   (pend_a_c),
    .pend_b_c   (pend_b_c)
  );

  // Read-port mux, optionally overriding with the write landing on this same edge.
  always_comb begin
    data_a_d = (rs == ADDR_W'(ZERO_REG)) ? '0 : regs_q[rs];
    data_b_d = (rt == ADDR_W'(ZERO_REG)) ? '0 : regs_q[rt];
    busy_a_d = pend_a_c;
    busy_b_d = pend_b_c;
`ifdef REGFILE_BYPASS_EN
    if (wr_hit_c && (rd == rs)) begin
      data_a_d = i_data;
      busy_a_d = sb_set && (sb_addr == rs);
    end
    if (wr_hit_c && (rd == rt)) begin
      data_b_d = i_data;
      busy_b_d = sb_set && (sb_addr == rt);
    end
`else
    // Same-edge reads see old state; control spaces dependent reads by a cycle.
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_a_q <= '0;
      data_b_q <= '0;
      busy_a_q <= 1'b0;
      busy_b_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= rd_en;
      if (rd_en) begin
        data_a_q <= data_a_d;
        data_b_q <= data_b_d;
        busy_a_q <= busy_a_d;
        busy_b_q <= busy_b_d;
      end
    end
  end

  assign out_data_a = data_a_q;
  assign out_data_b = data_b_q;
  assign busy_a     = busy_a_q;
  assign busy_b     = busy_b_q;
  assign out_valid  = valid_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a default 32x32 instance and an 8x16 sweep instance.
module tb_regfile_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // 32 x 32 instance
  logic [4:0]  rs, rt, rd, sb_addr;
  logic        wr_en, rd_en, sb_set;
  logic [31:0] i_data;
  logic [31:0] out_data_a, out_data_b;
  logic        out_valid, busy_a, busy_b;

  regfile_param dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .wr_en(wr_en),
    .i_data(i_data), .rd_en(rd_en), .sb_set(sb_set), .sb_addr(sb_addr),
    .out_data_a(out_data_a), .out_data_b(out_data_b), .out_valid(out_valid),
    .busy_a(busy_a), .busy_b(busy_b)
  );

  // 8 x 16 instance
  logic [2:0]  s_rs, s_rt, s_rd, s_sb_addr;
  logic        s_wr_en, s_rd_en, s_sb_set;
  logic [15:0] s_i_data;
  logic [15:0] s_out_a, s_out_b;
  logic        s_valid, s_busy_a, s_busy_b;

  regfile_param #(.DATA_W(16), .NUM_REGS(8)) dut_s (
    .clk(clk), .rst(rst), .rs(s_rs), .rt(s_rt), .rd(s_rd), .wr_en(s_wr_en),
    .i_data(s_i_data), .rd_en(s_rd_en), .sb_set(s_sb_set), .sb_addr(s_sb_addr),
    .out_data_a(s_out_a), .out_data_b(s_out_b), .out_valid(s_valid),
    .busy_a(s_busy_a), .busy_b(s_busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; sb_set = 1'b0;
    rs = '0; rt = '0; rd = '0; sb_addr = '0; i_data = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle(); wr_en = 1'b1; rd = a; i_data = d; tick(); idle();
  endtask

  task automatic rd2(input logic [4:0] a, input logic [4:0] b);
    idle(); rd_en = 1'b1; rs = a; rt = b; tick(); idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_a;
    logic [31:0] exp_busy;
    idle();
    s_wr_en = 1'b0; s_rd_en = 1'b0; s_sb_set = 1'b0;
    s_rs = '0; s_rt = '0; s_rd = '0; s_sb_addr = '0; s_i_data = '0;
    #2;
    check("rst_data_a", out_data_a, 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'({busy_a, busy_b}), 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Basic write then read
    wr(5'd5, 32'hDEADBEEF);
    rd2(5'd5, 5'd0);
    check("r5_a", out_data_a, 32'hDEADBEEF);
    check("r5_b_zero", out_data_b, 32'h0);
    check("r5_valid", 32'(out_valid), 32'h1);
    tick();
    check("valid_drop", 32'(out_valid), 32'h0);
    check("hold_a", out_data_a, 32'hDEADBEEF);

    // r0 write discarded
    wr(5'd0, 32'h1234);
    rd2(5'd0, 5'd5);
    check("r0_read", out_data_a, 32'h0);
    check("r0_b_r5", out_data_b, 32'hDEADBEEF);

    // Same-edge write and read of r7
    wr(5'd7, 32'h1);
    idle(); wr_en = 1'b1; rd = 5'd7; i_data = 32'hA5A5; rd_en = 1'b1; rs = 5'd7; rt = 5'd7;
    tick(); idle();
`ifdef REGFILE_BYPASS_EN
    exp_a = 32'hA5A5;
`else
    exp_a = 32'h1;
`endif
    check("same_edge_a", out_data_a, exp_a);
    check("same_edge_b", out_data_b, exp_a);
    rd_en = 1'b1; rs = 5'd7; rt = 5'd5; tick();
    rs = 5'd5; rt = 5'd7; tick(); idle();
    check("b2b_valid", 32'(out_valid), 32'h1);
    check("b2b_a", out_data_a, 32'hDEADBEEF);
    check("b2b_b", out_data_b, 32'hA5A5);

    // Scoreboard set / clear / priority
    idle(); sb_set = 1'b1; sb_addr = 5'd3; tick(); idle();
    rd2(5'd5, 5'd3);
    check("sb_busy_b", 32'(busy_b), 32'h1);
    check("sb_busy_a", 32'(busy_a), 32'h0);
    wr(5'd3, 32'h33);
    rd2(5'd3, 5'd3);
    check("sb_clr_b", 32'(busy_b), 32'h0);
    check("sb_clr_data", out_data_b, 32'h33);
    idle(); sb_set = 1'b1; sb_addr = 5'd3; wr_en = 1'b1; rd = 5'd3; i_data = 32'h44; tick(); idle();
    rd2(5'd0, 5'd3);
    check("sb_prio_busy", 32'(busy_b), 32'h1);
    check("sb_prio_data", out_data_b, 32'h44);
    idle(); sb_set = 1'b1; sb_addr = 5'd0; tick(); idle();
    rd2(5'd0, 5'd0);
    check("sb_r0_never", 32'(busy_a), 32'h0);

    // Same-edge write to a pending register while reading it
    idle(); sb_set = 1'b1; sb_addr = 5'd9; tick(); idle();
    idle(); wr_en = 1'b1; rd = 5'd9; i_data = 32'h99; rd_en = 1'b1; rs = 5'd9; rt = 5'd3; tick(); idle();
`ifdef REGFILE_BYPASS_EN
    exp_a = 32'h99; exp_busy = 32'h0;
`else
    exp_a = 32'h0;  exp_busy = 32'h1;
`endif
    check("byp_data_a", out_data_a, exp_a);
    check("byp_busy_a", 32'(busy_a), exp_busy);
    check("byp_busy_b", 32'(busy_b), 32'h1);

    // Mid-stream asynchronous reset
    wr(5'd10, 32'h77);
    idle(); sb_set = 1'b1; sb_addr = 5'd11; tick(); idle();
    rd_en = 1'b1; rs = 5'd10; rt = 5'd11; tick();
    check("pre_rst_a", out_data_a, 32'h77);
    check("pre_rst_busy_b", 32'(busy_b), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_a", out_data_a, 32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_busy", 32'({busy_a, busy_b}), 32'h0);
    tick(); idle();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1; rs = 5'(i); rt = 5'(31 - i); tick();
      check("post_rst_data", out_data_a | out_data_b, 32'h0);
      check("post_rst_busy", 32'({busy_a, busy_b}), 32'h0);
    end
    idle();

    // 8 x 16 sweep: ri holds i+1, r0 stays 0
    for (int i = 0; i < 8; i++) begin
      s_wr_en = 1'b1; s_rd = 3'(i); s_i_data = 16'(i + 1); tick();
    end
    s_wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        s_rd_en = 1'b1; s_rs = 3'(i); s_rt = 3'(j); tick();
        check("sweep_a", 32'(s_out_a), (i == 0) ? 32'h0 : 32'(i + 1));
        check("sweep_b", 32'(s_out_b), (j == 0) ? 32'h0 : 32'(j + 1));
      end
    end
    s_rd_en = 1'b0;
    tick();
    check("sweep_valid_drop", 32'(s_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multicycle register file for the custom processor datapath, replacing the per-register cell instances. It holds NUM_REGS words of DATA_W bits, with register 0 hardwired to zero. It has two registered read ports (rs → A, rt → B) captured on a read strobe and one synchronous write port (rd). A per-register pending-write scoreboard lets the control FSM stall on read-after-write hazards across multicycle instructions.

## Interface
- DATA_W, 32: word width.
- NUM_REGS, 32: number of registers; power of two, ≥ 2.
- ADDR_W, $clog2(NUM_REGS): register address width.
- clk  in  1: clock; all state updates on rising edge.
- rst  in  1: asynchronous, active-high reset.
- rs  in  ADDR_W: read address, port A.
- rt  in  ADDR_W: read address, port B.
- rd  in  ADDR_W: write address.
- wr_en  in  1: write strobe for i_data → reg[rd].
- i_data  in  DATA_W: write data.
- rd_en  in  1: read strobe; captures ports A/B.
- sb_set  in  1: mark reg[sb_addr] as pending write.
- sb_addr  in  ADDR_W: scoreboard set address.
- out_data_a  out  DATA_W: registered reg[rs].
- out_data_b  out  DATA_W: registered reg[rt].
- out_valid  out  1: one-cycle pulse, outputs updated.
- busy_a  out  1: registered pending flag of rs at capture.
- busy_b  out  1: registered pending flag of rt at capture.

## Operation
- Reset (async assert): all registers 0, scoreboard all clear, out_data_a/b = 0, out_valid = 0, busy_a/b = 0.
- Write: on edge with wr_en=1 and rd≠0, reg[rd] ← i_data, and scoreboard[rd] cleared. Writes to rd=0 are discarded. Scoreboard bit 0 is never set.
- Read: on edge with rd_en=1, the block updates:
  - out_data_a ← reg[rs] and out_data_b ← reg[rt], with 0 for address 0;
  - busy_a ← scoreboard[rs] and busy_b ← scoreboard[rt];
  - out_valid ← 1.
- With rd_en=0: outputs hold; out_valid ← 0.
- Scoreboard set: on edge with sb_set=1 and sb_addr≠0, scoreboard[sb_addr] ← 1.
- Simultaneous set and write-clear to the same address: set wins, because a new producer has issued.
- rs = rt: both ports return the same value.
- Read of an address being written the same edge: see Configuration.

## Timing
- Write latency: 1 cycle; the value is visible to an rd_en issued the following cycle.
- Read latency: 1 cycle; out_valid high in the cycle after rd_en.
- Back-to-back rd_en: out_valid stays high, and outputs update every cycle.
- Scoreboard latency: a set or clear takes effect in the state at the edge; busy reflects the state before that edge unless bypassed.
- Reset asserted mid-operation: immediate clear of all state; the first valid read is possible on the first edge after deassertion.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A same-edge write with wr_en and rd≠0 matching rs or rt forwards i_data into out_data_a/b.
  - The matching busy_a/b is forced to 0 unless a same-edge sb_set targets that address.
- REGFILE_BYPASS_EN undefined:
  - A same-edge read returns the old register value and the old scoreboard bit.
  - The control FSM must insert one cycle between a write and a dependent read.

## Structure
- Shared package regfile_pkg: DATA_W/NUM_REGS defaults, ADDR_W derivation, and a ZERO_REG = 0 constant.
- One sub-module, regfile_scoreboard: NUM_REGS-bit pending vector with set/clear/priority logic and two lookup ports. The storage array and read/bypass muxing stay in the top.

## Test plan
- Reset → write 32'hDEADBEEF to r5 → rd_en with rs=5, rt=0 → next cycle out_data_a=DEADBEEF, out_data_b=0, out_valid=1.
- Write 32'h1234 to r0, then read rs=0 → out_data_a=0.
- Same edge: wr_en rd=7 with i_data=32'hA5A5, plus rd_en rs=7, where r7 previously held 32'h1. With REGFILE_BYPASS_EN: out_data_a=A5A5. Without it: out_data_a=1, and the next read gives A5A5.
- sb_set on r3, then rd_en rt=3 → busy_b=1. Write r3, then read → busy_b=0. sb_set and write of r3 on the same edge → r3 still busy.
- Sweep NUM_REGS=8, DATA_W=16: write distinct value i+1 to each ri, read all pairs → correct values, and r0=0.
- Assert rst mid-stream, after writes and with scoreboard bits set → all outputs 0 immediately, every register reads 0, and all busy flags are 0 after release.
